msx_bus_target: RTL
===================

# msx_bus_target

Cartridge-side responder for the MSX slot bus. Oversamples the asynchronous Z80/MSX strobes in the fast CLK domain, classifies each bus cycle (slot memory read/write, I/O read/write), and hands it to internal logic through a single request/acknowledge port. It holds BUS_WAIT_n low until the internal side acknowledges, then drives read data. It sits between the slot pins and the cartridge's register/memory decoders.

## Interface
- SYNC_STAGES, 2: synchronizer depth for the strobe inputs (≥2).
- TIMEOUT, 255: maximum CLK cycles to wait for ACK before forced completion (1..65535).
- Reset RESET_n, asynchronous, active-low; clock CLK.
- CLK  in  1  system clock, ≥8× the bus clock.
- RESET_n  in  1  async active-low reset.
- BUS_RESET_n  in  1  slot reset; synchronized; low returns the FSM to IDLE.
- BUS_ADDR  in  16  slot address.
- BUS_DIN  in  8  data written by the host.
- BUS_MERQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n, BUS_M1_n, BUS_RFSH_n, BUS_SLTSL_n  in  1 each  host strobes.
- BUS_WAIT_n  out  1  wait request to the host, registered.
- BUS_DOUT  out  8  read data.
- BUS_DOUT_EN  out  1  data-bus drive enable.
- REQ  out  1  cycle request to internal logic.
- REQ_WR  out  1  1 = write, 0 = read.
- REQ_IO  out  1  1 = I/O cycle, 0 = slot memory cycle.
- REQ_ADDR  out  16  latched address.
- REQ_WDATA  out  8  latched write data.
- ACK  in  1  internal logic completion; sampled only while REQ=1.
- RDATA  in  8  read data, valid with ACK.
- TIMEOUT_P  out  1  one-cycle pulse on forced completion.

## Operation
- Strobes pass through a SYNC_STAGES flip-flop chain. BUS_ADDR and BUS_DIN are not synchronized; they are latched only at detection, when they are stable by bus protocol.
- Memory cycle: MERQ_n=0, SLTSL_n=0, RFSH_n=1, and (RD_n=0 or WR_n=0).
- I/O cycle: IORQ_n=0, M1_n=1, and (RD_n=0 or WR_n=0).
- Refresh cycles (RFSH_n=0) and interrupt acknowledge (IORQ_n=0 with M1_n=0) are ignored. They produce no REQ and no WAIT.
- FSM states:
  - IDLE: on detect, latch ADDR/DIN/type into REQ_* and go to REQ.
  - REQ: REQ=1, BUS_WAIT_n=0. On ACK, latch RDATA into BUS_DOUT (reads only), drop REQ, release WAIT, and go to HOLD. If the timer reaches TIMEOUT, set BUS_DOUT=8'hFF (reads only), pulse TIMEOUT_P, drop REQ, release WAIT, and go to HOLD.
  - HOLD: BUS_DOUT_EN=1 for reads only. Go to END when the synced RD_n and WR_n are both 1.
  - END: BUS_DOUT_EN=0. Go to IDLE when the synced MERQ_n and IORQ_n are both 1, so the same cycle is never detected twice.
- Timer is 16-bit. It clears on entering REQ, increments each CLK in REQ, and saturates.
- Synced BUS_RESET_n=0 forces IDLE from any state. All outputs return to their reset values next cycle; a pending ACK is discarded.
- An ACK that arrives while REQ=0 is ignored.
- ACK and timeout in the same cycle: ACK wins and TIMEOUT_P stays 0.

## Timing
- Reset values:
  - BUS_WAIT_n=1, BUS_DOUT=8'hFF, BUS_DOUT_EN=0, REQ=0, REQ_WR=0, REQ_IO=0, REQ_ADDR=0, REQ_WDATA=0, TIMEOUT_P=0.
  - FSM=IDLE, timer=0.
- Detection latency: SYNC_STAGES+1 CLK from the strobe edge to REQ=1 and BUS_WAIT_n=0, both in the same cycle.
- The CLK ≥ 8× bus clock requirement guarantees WAIT_n is low before the host samples it at T2.
- ACK sampled at cycle n gives REQ=0, BUS_WAIT_n=1, and BUS_DOUT valid at n+1. For reads, BUS_DOUT_EN=1 also at n+1.
- Minimum REQ width is 1 cycle; ACK may arrive in the first REQ cycle.
- BUS_DOUT_EN falls 1 cycle after synced RD_n returns high.
- BUS_DOUT holds its last value until the next read completes.

## Test plan
- Memory read:
  - Stimulus: SLTSL_n=0, MERQ_n=0, RD_n=0, ADDR=16'h4010; ACK with RDATA=8'hA5 after 3 REQ cycles.
  - Response: REQ_ADDR=16'h4010, REQ_WR=0, REQ_IO=0; WAIT_n low for 3 cycles; BUS_DOUT=8'hA5 with DOUT_EN=1 until RD_n rises.
- I/O write:
  - Stimulus: IORQ_n=0, WR_n=0, ADDR=16'h0098, DIN=8'h3C; immediate ACK.
  - Response: REQ_IO=1, REQ_WR=1, REQ_WDATA=8'h3C; DOUT_EN stays 0; exactly one REQ per cycle.
- Ignored cycles:
  - Stimulus: refresh cycle (MERQ_n=0, RFSH_n=0), then interrupt acknowledge (IORQ_n=0, M1_n=0).
  - Response: REQ=0 and WAIT_n=1 throughout.
- Timeout:
  - Stimulus: TIMEOUT=4, memory read, no ACK.
  - Response: WAIT_n released after 4 REQ cycles; BUS_DOUT=8'hFF; TIMEOUT_P pulses once.
- Bus reset during REQ:
  - Stimulus: BUS_RESET_n driven low while WAIT_n=0.
  - Response: IDLE within SYNC_STAGES+1 cycles, WAIT_n=1, REQ=0; a late ACK is ignored.
- Back-to-back:
  - Stimulus: two memory reads separated by one bus clock of MERQ_n high.
  - Response: two distinct REQs with the correct addresses.

Source files
------------

// File: rtl/msx_bus_target.sv
// MSX slot-bus target: synchronizes the host strobes, classifies memory/I/O cycles and
// hands each one to internal logic over REQ/ACK, holding BUS_WAIT_n low until completion.
module msx_bus_target #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        BUS_RESET_n,
  input  logic [15:0] BUS_ADDR,
  input  logic [7:0]  BUS_DIN,
  input  logic        BUS_MERQ_n,
  input  logic        BUS_IORQ_n,
  input  logic        BUS_RD_n,
  input  logic        BUS_WR_n,
  input  logic        BUS_M1_n,
  input  logic        BUS_RFSH_n,
  input  logic        BUS_SLTSL_n,
  output logic        BUS_WAIT_n,
  output logic [7:0]  BUS_DOUT,
  output logic        BUS_DOUT_EN,
  output logic        REQ,
  output logic        REQ_WR,
  output logic        REQ_IO,
  output logic [15:0] REQ_ADDR,
  output logic [7:0]  REQ_WDATA,
  input  logic        ACK,
  input  logic [7:0]  RDATA,
  output logic        TIMEOUT_P
);

  typedef struct packed {
    logic bus_rst_n;
    logic merq_n;
    logic iorq_n;
    logic rd_n;
    logic wr_n;
    logic m1_n;
    logic rfsh_n;
    logic sltsl_n;
  } strobe_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_END} state_e;

  strobe_t                   raw;
  strobe_t                   s;
  strobe_t [SYNC_STAGES-1:0] sync_q;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        wait_q, wait_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_en_q, dout_en_d;
  logic        req_wr_q, req_wr_d;
  logic        req_io_q, req_io_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [7:0]  req_wdata_q, req_wdata_d;
  logic        tmo_q, tmo_d;

  logic        mem_det, io_det, detect;
  logic [16:0] timer_inc;
  logic        timeout_hit;

  assign raw = {BUS_RESET_n, BUS_MERQ_n, BUS_IORQ_n, BUS_RD_n,
                BUS_WR_n, BUS_M1_n, BUS_RFSH_n, BUS_SLTSL_n};

  // Strobes idle high, so the chain resets to all ones to avoid a false detect.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      sync_q <= '1;
    end else begin
      // NOTE: non-blocking, so each stage captures the previous stage's old value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Refresh (RFSH_n low) and interrupt acknowledge (M1_n low) never qualify.
  assign mem_det = !s.merq_n && !s.sltsl_n && s.rfsh_n && (!s.rd_n || !s.wr_n);
  assign io_det  = !s.iorq_n && s.m1_n && (!s.rd_n || !s.wr_n);
  assign detect  = mem_det || io_det;

  assign timer_inc   = {1'b0, timer_q} + 17'd1;
  assign timeout_hit = (timer_inc >= 17'(TIMEOUT));

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      wait_q      <= 1'b1;
      dout_q      <= 8'hFF;
      dout_en_q   <= 1'b0;
      req_wr_q    <= 1'b0;
      req_io_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      wait_q      <= wait_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      req_wr_q    <= req_wr_d;
      req_io_q    <= req_io_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!s.bus_rst_n) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (detect)                state_d = S_REQ;
        S_REQ:   if (ACK || timeout_hit)    state_d = S_HOLD;
        S_HOLD:  if (s.rd_n && s.wr_n)      state_d = S_END;
        S_END:   if (s.merq_n && s.iorq_n)  state_d = S_IDLE;
        default:                            state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    timer_d     = timer_q;
    wait_d      = wait_q;
    dout_d      = dout_q;
    dout_en_d   = dout_en_q;
    req_wr_d    = req_wr_q;
    req_io_d    = req_io_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    tmo_d       = 1'b0;

    if (!s.bus_rst_n) begin
      timer_d     = '0;
      wait_d      = 1'b1;
      dout_d      = 8'hFF;
      dout_en_d   = 1'b0;
      req_wr_d    = 1'b0;
      req_io_d    = 1'b0;
      req_addr_d  = '0;
      req_wdata_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_d = '0;
          if (detect) begin
            req_wr_d    = !s.wr_n;
            req_io_d    = !mem_det;
            req_addr_d  = BUS_ADDR;
            req_wdata_d = BUS_DIN;
            wait_d      = 1'b0;
          end
        end
        S_REQ: begin
          timer_d = (timer_q == 16'hFFFF) ? timer_q : timer_inc[15:0];
          // ACK takes priority over a timeout landing in the same cycle.
          if (ACK) begin
            wait_d = 1'b1;
            if (!req_wr_q) begin
              dout_d    = RDATA;
              dout_en_d = 1'b1;
            end
          end else if (timeout_hit) begin
            wait_d = 1'b1;
            tmo_d  = 1'b1;
            if (!req_wr_q) begin
              dout_d    = 8'hFF;
              dout_en_d = 1'b1;
            end
          end
        end
        S_HOLD:  if (s.rd_n && s.wr_n) dout_en_d = 1'b0;
        S_END:   dout_en_d = 1'b0;
        default: dout_en_d = 1'b0;
      endcase
    end
  end

  assign BUS_WAIT_n  = wait_q;
  assign BUS_DOUT    = dout_q;
  assign BUS_DOUT_EN = dout_en_q;
  assign REQ         = (state_q == S_REQ);
  assign REQ_WR      = req_wr_q;
  assign REQ_IO      = req_io_q;
  assign REQ_ADDR    = req_addr_q;
  assign REQ_WDATA   = req_wdata_q;
  assign TIMEOUT_P   = tmo_q;

endmodule
